// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and sizing helpers for the binary layer engine
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } engine_state_t;

  localparam int DEFAULT_CHUNK = 64;

  // Two extra bits: one for the doubling of the popcount, one for the sign.
  function automatic int pre_width(input int in_width);
    return $clog2(in_width + 1) + 2;
  endfunction

endpackage

// File: rtl/bnn_layer_engine_popcount_tree.sv
// rtl/bnn_layer_engine_popcount_tree.sv - registered per-chunk popcounts with a combinational final adder
module popcount_tree
  import bnn_pkg::*;
#(
  parameter int IN_WIDTH = 512,
  parameter int CHUNK    = DEFAULT_CHUNK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           i_vec,
  output logic [$clog2(IN_WIDTH+1)-1:0] o_sum
);
  localparam int N_CHUNK = IN_WIDTH / CHUNK;
  localparam int CNT_W   = $clog2(CHUNK + 1);
  localparam int SUM_W   = $clog2(IN_WIDTH + 1);

  logic [CNT_W-1:0] w_cnt [N_CHUNK];
  logic [CNT_W-1:0] r_cnt [N_CHUNK];

  always_comb begin
    for (int c = 0; c < N_CHUNK; c++) begin
      w_cnt[c] = '0;
      for (int b = 0; b < CHUNK; b++) begin
        w_cnt[c] = w_cnt[c] + CNT_W'(i_vec[c*CHUNK + b]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CHUNK; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < N_CHUNK; c++) r_cnt[c] <= w_cnt[c];
    end
  end

  always_comb begin
    o_sum = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      o_sum = o_sum + SUM_W'(r_cnt[c]);
    end
  end

endmodule

// File: rtl/bnn_layer_engine.sv
// rtl/bnn_layer_engine.sv - XNOR/popcount fully-connected layer datapath, one neuron per accepted beat
module bnn_layer_engine
  import bnn_pkg::*;
#(
  parameter int IN_WIDTH    = 512,
  parameter int NUM_NEURONS = 1024,
  parameter int BIAS_WIDTH  = 2,
  parameter int CHUNK       = DEFAULT_CHUNK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   act_load,
  input  logic [IN_WIDTH-1:0]    act_in,
  input  logic                   w_valid,
  input  logic [IN_WIDTH-1:0]    weight_in,
  input  logic [BIAS_WIDTH-1:0]  bias_in,
  output logic [NUM_NEURONS-1:0] out_vec,
  output logic                   out_valid,
  output logic                   done,
  output logic                   busy
);
  localparam int PC_W  = $clog2(IN_WIDTH + 1);
  localparam int PRE_W = pre_width(IN_WIDTH);
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  engine_state_t r_state, w_next_state;

  logic [IN_WIDTH-1:0]    r_act;
  logic [CNT_W-1:0]       r_accept_cnt;
  logic [CNT_W-1:0]       r_write_cnt;
  logic [NUM_NEURONS-1:0] r_out_vec;
  logic                   r_done;

  logic                   r_s1_valid;
  logic [IN_WIDTH-1:0]    r_s1_xnor;
  logic [BIAS_WIDTH-1:0]  r_s1_bias;
  logic [IDX_W-1:0]       r_s1_idx;

  logic                   r_s2_valid;
  logic [BIAS_WIDTH-1:0]  r_s2_bias;
  logic [IDX_W-1:0]       r_s2_idx;

  logic                   w_accept;
  logic [PC_W-1:0]        w_sum;
  logic [PRE_W-1:0]       w_bias_ext;
  logic signed [PRE_W-1:0] w_pre;
  logic                   w_bit;

  // act_load always wins over a coincident beat.
  assign w_accept = (r_state == RUN) && w_valid && !act_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (act_load) w_next_state = RUN;
      RUN: begin
        if (act_load) w_next_state = RUN;
        else if (w_accept && (r_accept_cnt == CNT_W'(NUM_NEURONS - 1))) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (act_load) w_next_state = RUN;
        else if (r_write_cnt == CNT_W'(NUM_NEURONS)) w_next_state = DONE;
      end
      DONE:  if (act_load) w_next_state = RUN;
      default: w_next_state = IDLE;
    endcase
  end

  popcount_tree #(
    .IN_WIDTH(IN_WIDTH),
    .CHUNK   (CHUNK)
  ) u_popcount (
    .clk  (clk),
    .rst  (rst),
    .i_vec(r_s1_xnor),
    .o_sum(w_sum)
  );

  // pre = 2*pc - IN_WIDTH + bias; only its sign matters, zero counts as positive.
  assign w_bias_ext = {{(PRE_W-BIAS_WIDTH){r_s2_bias[BIAS_WIDTH-1]}}, r_s2_bias};
  assign w_pre      = {1'b0, w_sum, 1'b0} - PRE_W'(IN_WIDTH) + w_bias_ext;
  assign w_bit      = (w_pre >= $signed({PRE_W{1'b0}}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act        <= '0;
      r_accept_cnt <= '0;
      r_write_cnt  <= '0;
      r_out_vec    <= '0;
      r_done       <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_xnor    <= '0;
      r_s1_bias    <= '0;
      r_s1_idx     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_bias    <= '0;
      r_s2_idx     <= '0;
    end else begin
      r_done <= (r_state == DRAIN) && (w_next_state == DONE);
      if (act_load) begin
        r_act        <= act_in;
        r_accept_cnt <= '0;
        r_write_cnt  <= '0;
        r_out_vec    <= '0;
        r_s1_valid   <= 1'b0;
        r_s2_valid   <= 1'b0;
      end else begin
        r_s1_valid <= w_accept;
        r_s2_valid <= r_s1_valid;
        if (w_accept) begin
          r_accept_cnt <= r_accept_cnt + 1'b1;
          r_s1_xnor    <= ~(r_act ^ weight_in);
          r_s1_bias    <= bias_in;
          r_s1_idx     <= r_accept_cnt[IDX_W-1:0];
        end
        if (r_s1_valid) begin
          r_s2_bias <= r_s1_bias;
          r_s2_idx  <= r_s1_idx;
        end
        if (r_s2_valid) begin
          r_out_vec[r_s2_idx] <= w_bit;
          r_write_cnt         <= r_write_cnt + 1'b1;
        end
      end
    end
  end

  assign out_vec   = r_out_vec;
  assign out_valid = (r_state == DONE);
  assign done      = r_done;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);

endmodule
